// File: rtl/gpio_input_capture.sv
// gpio_input_capture: synchronises raw GPIO pins, latches sticky rise/fall
// flags, counts masked rising events and exposes everything as a small
// register bank on the SPI slave's address/strobe/data bus.
module gpio_input_capture #(
  parameter int          WIDTH      = 10,
  parameter int          DATA_WIDTH = 16,
  parameter logic [15:0] BASE_ADDR  = 16'h0002
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [WIDTH-1:0]      i_pins,
  input  logic [15:0]           i_address,
  input  logic                  i_reg_read_strobe,
  input  logic                  i_reg_write_strobe,
  input  logic [DATA_WIDTH-1:0] i_write_data,
  output logic [DATA_WIDTH-1:0] o_read_data,
  output logic                  o_read_valid,
  output logic                  o_irq
);

  localparam logic [2:0] OFF_LEVEL = 3'd0;
  localparam logic [2:0] OFF_RISE  = 3'd1;
  localparam logic [2:0] OFF_FALL  = 3'd2;
  localparam logic [2:0] OFF_COUNT = 3'd3;
  localparam logic [2:0] OFF_MASK  = 3'd4;

  logic [WIDTH-1:0]      sync1;
  logic [WIDTH-1:0]      sync2;
  logic [WIDTH-1:0]      prev;
  logic [WIDTH-1:0]      rise;
  logic [WIDTH-1:0]      fall;
  logic [WIDTH-1:0]      rise_flags;
  logic [WIDTH-1:0]      fall_flags;
  logic [WIDTH-1:0]      irq_mask;
  logic [15:0]           event_count;
  logic [1:0]            warm_cnt;
  logic                  warm_done;
  logic [15:0]           addr_offset;
  logic [2:0]            offset_sel;
  logic                  addr_hit;
  logic                  do_read;
  logic                  do_write_mask;
  logic                  clr_rise;
  logic                  clr_fall;
  logic                  clr_count;
  logic                  count_inc;
  logic [DATA_WIDTH-1:0] read_mux;
  logic                  unused_write_bits;

  // Only the low WIDTH bits of the write bus land in the mask register.
  assign unused_write_bits = ^i_write_data;

  // Edge detection stays off until the synchroniser has flushed the reset
  // zeros, so a pin held high through reset is not mistaken for a rise.
  assign warm_done = (warm_cnt == 2'd3);
  assign rise      = warm_done ? (sync2 & ~prev) : '0;
  assign fall      = warm_done ? (~sync2 & prev) : '0;
  assign count_inc = |(rise & irq_mask);

  // Address decode covers BASE_ADDR..BASE_ADDR+4; a simultaneous write wins
  // over a read, so the read (and its clear side effect) is dropped.
  assign addr_offset   = i_address - BASE_ADDR;
  assign offset_sel    = addr_offset[2:0];
  assign addr_hit      = (i_address >= BASE_ADDR) && (addr_offset <= 16'd4);
  assign do_read       = i_reg_read_strobe && !i_reg_write_strobe && addr_hit;
  assign do_write_mask = i_reg_write_strobe && addr_hit && (offset_sel == OFF_MASK);
  assign clr_rise      = do_read && (offset_sel == OFF_RISE);
  assign clr_fall      = do_read && (offset_sel == OFF_FALL);
  assign clr_count     = do_read && (offset_sel == OFF_COUNT);

  // Register read multiplexer, zero-extending each field to the data bus.
  always_comb begin
    read_mux = '0;
    case (offset_sel)
      OFF_LEVEL: read_mux = DATA_WIDTH'(sync2);
      OFF_RISE:  read_mux = DATA_WIDTH'(rise_flags);
      OFF_FALL:  read_mux = DATA_WIDTH'(fall_flags);
      OFF_COUNT: read_mux = DATA_WIDTH'(event_count);
      OFF_MASK:  read_mux = DATA_WIDTH'(irq_mask);
      default:   read_mux = '0;
    endcase
  end

  // Counts cycles since reset release until edge detection is allowed.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      warm_cnt <= 2'd0;
    end else if (!warm_done) begin
      warm_cnt <= warm_cnt + 2'd1;
    end
  end

  // Two-flop synchroniser per pin plus a delayed copy for edge detection.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
    end else begin
      sync1 <= i_pins;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  // Sticky edge flags; a fresh edge on the same cycle as a clearing read survives.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rise_flags <= '0;
      fall_flags <= '0;
    end else begin
      rise_flags <= (clr_rise ? '0 : rise_flags) | rise;
      fall_flags <= (clr_fall ? '0 : fall_flags) | fall;
    end
  end

  // Saturating counter of cycles with at least one masked rising edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      event_count <= 16'd0;
    end else if (clr_count) begin
      event_count <= count_inc ? 16'd1 : 16'd0;
    end else if (count_inc && (event_count != 16'hFFFF)) begin
      event_count <= event_count + 16'd1;
    end
  end

  // Interrupt mask, the only writable register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      irq_mask <= '0;
    end else if (do_write_mask) begin
      irq_mask <= i_write_data[WIDTH-1:0];
    end
  end

  // Registered read data that holds until the next decoded read, plus its strobe.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_read_data  <= '0;
      o_read_valid <= 1'b0;
    end else begin
      o_read_valid <= do_read;
      if (do_read) begin
        o_read_data <= read_mux;
      end
    end
  end

  // Interrupt is raised while any masked rising flag is pending.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_irq <= 1'b0;
    end else begin
      o_irq <= |(rise_flags & irq_mask);
    end
  end

endmodule

// File: tb/tb_gpio_input_capture.sv
// tb_gpio_input_capture: directed and randomised checks of gpio_input_capture
// against a cycle-level reference model built from the pin sample history.
module tb_gpio_input_capture;

  localparam int          WIDTH = 10;
  localparam int          DW    = 16;
  localparam logic [15:0] BASE  = 16'h0002;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] pins;
  logic [15:0]      address;
  logic             rd;
  logic             wr;
  logic [DW-1:0]    wdata;
  logic [DW-1:0]    rdata;
  logic             rvalid;
  logic             irq;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state
  logic [WIDTH-1:0] m_samples[$];
  logic [WIDTH-1:0] m_rise;
  logic [WIDTH-1:0] m_fall;
  logic [WIDTH-1:0] m_mask;
  logic [15:0]      m_count;
  logic [DW-1:0]    m_rdata;
  logic             m_rvalid;
  logic             m_irq;
  logic [WIDTH-1:0] cur_pins;

  gpio_input_capture #(
    .WIDTH      (WIDTH),
    .DATA_WIDTH (DW),
    .BASE_ADDR  (BASE)
  ) dut (
    .i_clk              (clk),
    .i_rst_n            (rst_n),
    .i_pins             (pins),
    .i_address          (address),
    .i_reg_read_strobe  (rd),
    .i_reg_write_strobe (wr),
    .i_write_data       (wdata),
    .o_read_data        (rdata),
    .o_read_valid       (rvalid),
    .o_irq              (irq)
  );

  // Free-running 100 MHz-style clock for simulation
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_samples.delete();
    m_rise   = '0;
    m_fall   = '0;
    m_mask   = '0;
    m_count  = '0;
    m_rdata  = '0;
    m_rvalid = 1'b0;
    m_irq    = 1'b0;
  endtask

  // Pin value sampled at edge k after reset release (k starts at 1), 0 before that.
  function automatic logic [WIDTH-1:0] sample_at(input int k);
    if (k >= 1 && k <= m_samples.size()) return m_samples[k-1];
    return '0;
  endfunction

  function automatic logic [DW-1:0] reg_value(input int off, input logic [WIDTH-1:0] lvl);
    logic [DW-1:0] r;
    r = '0;
    case (off)
      0: r[WIDTH-1:0] = lvl;
      1: r[WIDTH-1:0] = m_rise;
      2: r[WIDTH-1:0] = m_fall;
      3: r = m_count;
      4: r[WIDTH-1:0] = m_mask;
      default: r = '0;
    endcase
    return r;
  endfunction

  // One clock edge of the reference model: the synchronised level is the pin
  // value from two edges back, an edge is a change between two and three back.
  task automatic model_step(input logic [WIDTH-1:0] p, input logic [15:0] a,
                            input logic r, input logic w, input logic [DW-1:0] d);
    int n;
    int off;
    logic [WIDTH-1:0] lvl, older, rise_ev, fall_ev;
    logic hit, do_read, inc, irq_next;
    logic [15:0] base_cnt;
    n       = m_samples.size() + 1;
    lvl     = sample_at(n - 2);
    older   = sample_at(n - 3);
    rise_ev = (n >= 4) ? (lvl & ~older) : '0;
    fall_ev = (n >= 4) ? (~lvl & older) : '0;
    off     = int'(a) - int'(BASE);
    hit     = (off >= 0) && (off <= 4);
    do_read = r && !w && hit;
    irq_next = |(m_rise & m_mask);
    inc     = |(rise_ev & m_mask);
    m_rvalid = do_read;
    if (do_read) m_rdata = reg_value(off, lvl);
    base_cnt = (do_read && off == 3) ? 16'd0 : m_count;
    if (inc && base_cnt != 16'hFFFF) base_cnt = base_cnt + 16'd1;
    m_count = base_cnt;
    m_rise  = ((do_read && off == 1) ? '0 : m_rise) | rise_ev;
    m_fall  = ((do_read && off == 2) ? '0 : m_fall) | fall_ev;
    if (w && hit && off == 4) m_mask = d[WIDTH-1:0];
    m_samples.push_back(p);
    m_irq = irq_next;
  endtask

  task automatic check_output(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, advance the model on the edge and compare outputs.
  task automatic apply_stimulus(input logic [WIDTH-1:0] p, input logic [15:0] a,
                                input logic r, input logic w, input logic [DW-1:0] d);
    pins    = p;
    address = a;
    rd      = r;
    wr      = w;
    wdata   = d;
    @(posedge clk);
    model_step(p, a, r, w, d);
    #1;
    check_output("read_valid", 16'(rvalid), 16'(m_rvalid));
    check_output("read_data", rdata, m_rdata);
    check_output("irq", 16'(irq), 16'(m_irq));
    rd = 1'b0;
    wr = 1'b0;
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) apply_stimulus(cur_pins, 16'h0000, 1'b0, 1'b0, '0);
  endtask

  task automatic read_reg(input int off);
    apply_stimulus(cur_pins, BASE + 16'(off), 1'b1, 1'b0, '0);
  endtask

  task automatic write_reg(input int off, input logic [DW-1:0] d);
    apply_stimulus(cur_pins, BASE + 16'(off), 1'b0, 1'b1, d);
  endtask

  initial begin
    // Reset with all pins held high
    rst_n    = 1'b0;
    cur_pins = 10'h3FF;
    pins     = cur_pins;
    address  = '0;
    rd       = 1'b0;
    wr       = 1'b0;
    wdata    = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_output("rst_read_data", rdata, 16'h0000);
    check_output("rst_read_valid", 16'(rvalid), 16'h0000);
    check_output("rst_irq", 16'(irq), 16'h0000);
    rst_n = 1'b1;
    write_reg(4, 16'h03FF);
    idle(5);
    read_reg(1);
    check_output("warm_rise", rdata, 16'h0000);
    read_reg(2);
    check_output("warm_fall", rdata, 16'h0000);
    read_reg(3);
    check_output("warm_count", rdata, 16'h0000);
    check_output("warm_irq", 16'(irq), 16'h0000);

    // Single masked rising edge on pin0
    write_reg(4, 16'h0001);
    cur_pins = '0;
    idle(4);
    read_reg(2);
    check_output("fall_all", rdata, 16'h03FF);
    read_reg(1);
    check_output("rise_clear", rdata, 16'h0000);
    cur_pins = 10'h001;
    idle(3);
    check_output("irq_not_yet", 16'(irq), 16'h0000);
    idle(1);
    check_output("irq_at_4", 16'(irq), 16'h0001);
    read_reg(1);
    check_output("rise_bit0", rdata, 16'h0001);
    check_output("rise_bit0_valid", 16'(rvalid), 16'h0001);
    read_reg(1);
    check_output("rise_reread", rdata, 16'h0000);
    check_output("irq_dropped", 16'(irq), 16'h0000);

    // Pin3 edge lands on the same edge as a RISE read
    cur_pins = 10'h009;
    idle(2);
    read_reg(1);
    check_output("race_read", rdata, 16'h0000);
    read_reg(1);
    check_output("race_survive", rdata, 16'h0008);

    // Counter saturation
    write_reg(4, 16'h03FF);
    read_reg(3);
    for (int i = 0; i < 70000; i++) begin
      cur_pins = (i % 2 == 0) ? 10'h155 : 10'h2AA;
      idle(1);
    end
    idle(4);
    read_reg(3);
    check_output("count_sat", rdata, 16'hFFFF);
    read_reg(3);
    check_output("count_cleared", rdata, 16'h0000);
    read_reg(1);
    read_reg(2);

    // Level read, address miss, ignored and combined writes
    cur_pins = 10'h2A5;
    idle(3);
    read_reg(0);
    check_output("level", rdata, 16'h02A5);
    read_reg(5);
    check_output("miss_valid", 16'(rvalid), 16'h0000);
    check_output("miss_hold", rdata, 16'h02A5);
    write_reg(0, 16'hFFFF);
    read_reg(0);
    check_output("level_ro", rdata, 16'h02A5);
    apply_stimulus(cur_pins, BASE - 16'd1, 1'b0, 1'b1, 16'h0000);
    apply_stimulus(cur_pins, BASE + 16'd4, 1'b1, 1'b1, 16'h0055);
    check_output("rw_no_valid", 16'(rvalid), 16'h0000);
    read_reg(4);
    check_output("mask_rw", rdata, 16'h0055);

    // Randomised traffic against the model
    for (int i = 0; i < 3000; i++) begin
      logic r, w;
      logic [15:0] a;
      if ($urandom_range(0, 3) == 0) cur_pins = cur_pins ^ WIDTH'($urandom);
      r = ($urandom_range(0, 3) == 0);
      w = ($urandom_range(0, 7) == 0);
      a = BASE - 16'd1 + 16'($urandom_range(0, 6));
      apply_stimulus(cur_pins, a, r, w, DW'($urandom));
    end

    // Reset in the middle of counting
    write_reg(4, 16'h03FF);
    cur_pins = '0;
    idle(4);
    read_reg(3);
    read_reg(1);
    read_reg(2);
    for (int i = 0; i < 5; i++) begin
      cur_pins = 10'h001;
      idle(2);
      cur_pins = 10'h000;
      idle(2);
    end
    idle(4);
    read_reg(4);
    check_output("pre_rst_irq", 16'(irq), 16'h0001);
    check_output("pre_rst_data", rdata, 16'h03FF);
    cur_pins = 10'h3FF;
    pins     = cur_pins;
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_output("async_rst_data", rdata, 16'h0000);
    check_output("async_rst_valid", 16'(rvalid), 16'h0000);
    check_output("async_rst_irq", 16'(irq), 16'h0000);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(5);
    read_reg(1);
    check_output("post_rst_rise", rdata, 16'h0000);
    read_reg(2);
    check_output("post_rst_fall", rdata, 16'h0000);
    read_reg(3);
    check_output("post_rst_count", rdata, 16'h0000);
    read_reg(4);
    check_output("post_rst_mask", rdata, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
